// File: rtl/sysid_regbank_if.sv
// Avalon-MM control-bus bundle for the sysid register bank.
// Latency: none, wires only.
// Backpressure: none, the bus has no waitrequest.
interface sysid_regbank_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_regbank.sv
// System-ID slave: build ID, timestamp, scratch, lockable CTRL, optional uptime counter (SYSID_UPTIME_EN).
// Latency: read data READ_LATENCY cycles after the read is accepted; writes land on the next edge.
// Backpressure: none, every read and write is accepted in the cycle it is presented.
module sysid_regbank #(
    parameter logic [31:0] ID           = 32'hC0DE_0001,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          ADDR_W       = 3,
    parameter int          READ_LATENCY = 1,
    parameter int          CNT_W        = 48
) (
    input logic             clock,
    input logic             reset_n,
    sysid_regbank_if.slave  bus
);

    // Parameter range guards, evaluated at elaboration.
    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("sysid_regbank: ADDR_W must be at least 3");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("sysid_regbank: READ_LATENCY must be in 1..4");
    end
    if (CNT_W < 33 || CNT_W > 64) begin : g_bad_cnt_w
        $error("sysid_regbank: CNT_W must be in 33..64");
    end

    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TS      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(5);

    logic [31:0] scratch_q;
    logic        lock_q;
    logic        wr_ctrl;
    logic        wr_scratch;
    logic [31:0] uptime_lo;
    logic [31:0] uptime_hi;
    logic        wrap_bit;
    logic [31:0] rd_mux;

    // CTRL only looks at the low byte lane; SCRATCH is frozen once LOCK is set.
    assign wr_ctrl    = bus.write && (bus.address == A_CTRL) && bus.byteenable[0];
    assign wr_scratch = bus.write && (bus.address == A_SCRATCH) && !lock_q;

`ifdef SYSID_UPTIME_EN
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      shadow_q;
    logic             wrap_q;
    logic [63:0]      cnt_ext;
    logic             cnt_max;
    logic             cnt_clr;
    logic             wrap_clr;

    assign cnt_ext  = 64'(cnt_q);
    assign cnt_max  = &cnt_q;
    assign cnt_clr  = wr_ctrl && bus.writedata[1];
    assign wrap_clr = wr_ctrl && bus.writedata[2];

    // Free-running uptime counter; a CNT_CLR write zeroes it on the following edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Reading the low word latches the upper bits so the next high-word read is coherent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
        end else if (bus.read && (bus.address == A_UP_LO)) begin
            shadow_q <= cnt_ext[63:32];
        end
    end

    // Sticky wrap flag: a clear beats the wrap, a new wrap beats a W1C.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else if (cnt_max && !cnt_clr) begin
            wrap_q <= 1'b1;
        end else if (wrap_clr) begin
            wrap_q <= 1'b0;
        end
    end

    assign uptime_lo = cnt_ext[31:0];
    assign uptime_hi = shadow_q;
    assign wrap_bit  = wrap_q;
`else
    assign uptime_lo = '0;
    assign uptime_hi = '0;
    assign wrap_bit  = 1'b0;
`endif

    // Byte-lane writes into SCRATCH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= '0;
        end else if (wr_scratch) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    scratch_q[8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    // LOCK is set-only; only reset clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= 1'b0;
        end else if (wr_ctrl && bus.writedata[0]) begin
            lock_q <= 1'b1;
        end
    end

    // Read decode from current register state, so a same-cycle write is not yet visible.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_ID:      rd_mux = ID;
            A_TS:      rd_mux = TIMESTAMP;
            A_UP_LO:   rd_mux = uptime_lo;
            A_UP_HI:   rd_mux = uptime_hi;
            A_SCRATCH: rd_mux = scratch_q;
            A_CTRL:    rd_mux = {29'd0, wrap_bit, 1'b0, lock_q};
            default:   rd_mux = '0;
        endcase
    end

    logic [READ_LATENCY-1:0] vld_q;
    logic [31:0]             dat_q [READ_LATENCY];

    // Fixed-latency read pipeline; data stages only move with valid so readdata holds between results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= bus.read;
            if (bus.read) begin
                dat_q[0] <= rd_mux;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign bus.readdata      = dat_q[READ_LATENCY-1];
    assign bus.readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regbank.sv
// Directed bench for sysid_regbank: two instances (READ_LATENCY 1 and 4) see identical bus traffic.
// Latency: each read is expected exactly READ_LATENCY cycles after issue on each instance.
// Backpressure: none on this bus; readdatavalid is checked every cycle against a per-instance queue.
module tb_sysid_regbank;

    logic        clock;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    logic [31:0] last1 = '0;
    logic [31:0] last4 = '0;

    // Uptime model: counter value cnt_base during cycle cnt_cyc.
    longint cnt_base = 0;
    int     cnt_cyc  = 0;

    sysid_regbank_if #(.ADDR_W(3)) if1 ();
    sysid_regbank_if #(.ADDR_W(3)) if4 ();

    assign if1.address    = address;
    assign if1.read       = read;
    assign if1.write      = write;
    assign if1.writedata  = writedata;
    assign if1.byteenable = byteenable;
    assign if4.address    = address;
    assign if4.read       = read;
    assign if4.write      = write;
    assign if4.writedata  = writedata;
    assign if4.byteenable = byteenable;

    sysid_regbank #(.ID(32'hC0DE_0001), .TIMESTAMP(32'h0000_0000), .ADDR_W(3),
                    .READ_LATENCY(1), .CNT_W(33)) u_dut_l1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if1)
    );

    sysid_regbank #(.ID(32'hC0DE_0001), .TIMESTAMP(32'h0000_0000), .ADDR_W(3),
                    .READ_LATENCY(4), .CNT_W(33)) u_dut_l4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [32:0] cnt_at(input int c);
        return 33'(cnt_base + longint'(c - cnt_cyc));
    endfunction

    // Result scoreboard for both instances, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset_n) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                check("l1_vld", 32'(if1.readdatavalid), 32'd1);
                check("l1_dat", if1.readdata, q1[0].dat);
                last1 = q1[0].dat;
                void'(q1.pop_front());
            end else begin
                check("l1_idle_vld", 32'(if1.readdatavalid), 32'd0);
                check("l1_hold", if1.readdata, last1);
            end
            if (q4.size() > 0 && q4[0].due == cyc) begin
                check("l4_vld", 32'(if4.readdatavalid), 32'd1);
                check("l4_dat", if4.readdata, q4[0].dat);
                last4 = q4[0].dat;
                void'(q4.pop_front());
            end else begin
                check("l4_idle_vld", 32'(if4.readdatavalid), 32'd0);
                check("l4_hold", if4.readdata, last4);
            end
        end
    end

    // One bus cycle, entered and left at a falling edge.
    task automatic bus_op(input logic rd, input logic wr, input int addr,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
        exp_t e;
        address    = 3'(addr);
        read       = rd;
        write      = wr;
        writedata  = wd;
        byteenable = be;
        if (rd) begin
            e.dat = exp;
            e.due = cyc + 1;
            q1.push_back(e);
            e.due = cyc + 4;
            q4.push_back(e);
        end
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic do_read(input int addr, input logic [31:0] exp);
        bus_op(1'b1, 1'b0, addr, 32'd0, 4'd0, exp);
    endtask

    task automatic do_write(input int addr, input logic [31:0] wd, input logic [3:0] be);
        bus_op(1'b0, 1'b1, addr, wd, be, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [32:0] v;
        int c;
        reset_n    = 1'b0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;

        // Reset state.
        idle(3);
        check("rst_rd_l1",  if1.readdata, 32'd0);
        check("rst_vld_l1", 32'(if1.readdatavalid), 32'd0);
        check("rst_rd_l4",  if4.readdata, 32'd0);
        check("rst_vld_l4", 32'(if4.readdatavalid), 32'd0);
        reset_n  = 1'b1;
        cnt_base = 0;
        cnt_cyc  = cyc;
        idle(2);

        // ID and TIMESTAMP back-to-back.
        do_read(0, 32'hC0DE_0001);
        do_read(1, 32'h0000_0000);
        idle(6);

        // SCRATCH reset value, unmapped addresses, CTRL reset value.
        do_read(4, 32'd0);
        do_read(7, 32'd0);
        do_read(6, 32'd0);
        do_read(5, 32'd0);
        idle(6);

        // Byte-lane writes.
        do_write(4, 32'hFFFF_FFFF, 4'b0101);
        do_read(4, 32'h00FF_00FF);
        do_write(4, 32'h1122_3344, 4'b1000);
        do_read(4, 32'h11FF_00FF);

        // Same-cycle read and write returns the old value.
        bus_op(1'b1, 1'b1, 4, 32'hDEAD_BEEF, 4'b1111, 32'h11FF_00FF);
        do_read(4, 32'hDEAD_BEEF);

        // CTRL write with lane 0 disabled is ignored.
        do_write(5, 32'h0000_0001, 4'b1110);
        do_read(5, 32'd0);
        do_write(4, 32'hCAFE_F00D, 4'b1111);
        do_read(4, 32'hCAFE_F00D);

        // Lock, then SCRATCH is frozen.
        do_write(5, 32'h0000_0001, 4'b0001);
        do_write(4, 32'h1234_5678, 4'b1111);
        do_read(4, 32'hCAFE_F00D);
        do_read(5, 32'd1);

        // Writing 0 never clears LOCK.
        do_write(5, 32'h0000_0000, 4'b1111);
        do_read(5, 32'd1);
        idle(6);

`ifdef SYSID_UPTIME_EN
        // CNT_CLR: counter restarts at 0 the cycle after the write.
        c = cyc;
        do_write(5, 32'h0000_0006, 4'b0001);
        cnt_base = 0;
        cnt_cyc  = c + 1;
        v = cnt_at(cyc);
        do_read(2, v[31:0]);
        do_read(5, 32'd1);
        idle(6);

        // Coherent low/high pair just below the wrap, then sticky WRAP and W1C.
        force u_dut_l1.cnt_q = 33'h1_FFFF_FFFC;
        force u_dut_l4.cnt_q = 33'h1_FFFF_FFFC;
        release u_dut_l1.cnt_q;
        release u_dut_l4.cnt_q;
        cnt_base = 64'h1_FFFF_FFFC;
        cnt_cyc  = cyc;
        v = cnt_at(cyc);
        do_read(2, v[31:0]);
        do_read(3, {31'd0, v[32]});
        idle(4);
        do_read(5, 32'd5);
        v = cnt_at(cyc);
        do_read(2, v[31:0]);
        do_write(5, 32'h0000_0004, 4'b0001);
        do_read(5, 32'd1);
        idle(6);

        // CNT_CLR in the wrap cycle: clear wins, no WRAP.
        force u_dut_l1.cnt_q = 33'h1_FFFF_FFFC;
        force u_dut_l4.cnt_q = 33'h1_FFFF_FFFC;
        release u_dut_l1.cnt_q;
        release u_dut_l4.cnt_q;
        idle(3);
        c = cyc;
        do_write(5, 32'h0000_0002, 4'b0001);
        cnt_base = 0;
        cnt_cyc  = c + 1;
        v = cnt_at(cyc);
        do_read(2, v[31:0]);
        do_read(5, 32'd1);
        idle(6);

        // WRAP clear in the wrap cycle: set wins.
        force u_dut_l1.cnt_q = 33'h1_FFFF_FFFC;
        force u_dut_l4.cnt_q = 33'h1_FFFF_FFFC;
        release u_dut_l1.cnt_q;
        release u_dut_l4.cnt_q;
        idle(3);
        do_write(5, 32'h0000_0004, 4'b0001);
        do_read(5, 32'd5);
        do_write(5, 32'h0000_0004, 4'b0001);
        do_read(5, 32'd1);
        idle(6);
`else
        // Without the counter: uptime words read 0, CTRL bits 1 and 2 stay 0.
        do_read(2, 32'd0);
        do_read(3, 32'd0);
        do_write(5, 32'h0000_0006, 4'b0001);
        do_read(5, 32'd1);
        idle(6);
`endif

        // Reset with reads in flight: latency-4 results must never appear.
        do_read(4, 32'hCAFE_F00D);
        do_read(0, 32'hC0DE_0001);
        do_read(5, 32'd1);
        #2;
        reset_n = 1'b0;
        q1.delete();
        q4.delete();
        last1 = '0;
        last4 = '0;
        @(negedge clock);
        check("midrst_vld_l4", 32'(if4.readdatavalid), 32'd0);
        check("midrst_rd_l4",  if4.readdata, 32'd0);
        #2;
        reset_n  = 1'b1;
        cnt_base = 0;
        cnt_cyc  = cyc;
        @(negedge clock);
        idle(8);

        // LOCK and SCRATCH are back to 0, and SCRATCH is writable again.
        do_read(4, 32'd0);
        do_read(5, 32'd0);
        do_write(4, 32'h5A5A_A5A5, 4'b1111);
        do_read(4, 32'h5A5A_A5A5);
        idle(8);

        check("queues_drained", 32'(q1.size() + q4.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
